skid_buffer: RTL and testbench

- Registered valid/ready pipeline stage directly downstream of mux2; consumes the selected word (mux2 out) and presents it to the next stage.
- Two-entry storage: main output register plus skid register.
- Gives a full-throughput register boundary whose in_ready is a registered signal, so no combinational ready path runs back through the mux.
- Standard cut point after any mux2 in the datapath.

---
 rtl/skid_buffer.sv | 107 ++++++++++
 tb/tb_skid_buffer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// Registered valid/ready cut point with one output word and one skid word.
// Both in_ready and out_valid come straight from flops, so no combinational ready path crosses the stage.
//   state | meaning
//   EMPTY | nothing held, out_valid=0, in_ready=1
//   BUSY  | main holds one word, out_valid=1, in_ready=1
//   FULL  | main and skid both hold words, in_ready=0
module skid_buffer #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] main_q, main_d;
  logic [n-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = EMPTY;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d      = in_data;
            state_d     = BUSY;
            out_valid_d = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d     = in_data;
            state_d    = FULL;
            in_ready_d = 1'b0;
          end else if (out_fire) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;
          end
        end
        FULL: begin
          // Skid word always follows the main word, preserving FIFO order.
          if (out_fire) begin
            main_d     = skid_q;
            state_d    = BUSY;
            in_ready_d = 1'b1;
          end
        end
        default: begin
          state_d     = EMPTY;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: directed scenarios plus a random phase, all outputs checked
// against a scoreboard queue filled on accepted inputs and drained on accepted outputs.
module tb_skid_buffer;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   occupancy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [N-1:0] sb[$];

  skid_buffer #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [1:0] occ, input logic vld, input logic rdy);
    check({tag, "_occ"}, 32'(occupancy), 32'(occ));
    check({tag, "_vld"}, 32'(out_valid), 32'(vld));
    check({tag, "_rdy"}, 32'(in_ready), 32'(rdy));
  endtask

  // Inputs change at posedge+1, so the negedge sees exactly what the next edge will commit.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", 32'(out_data), 32'hDEAD_BEEF);
        else check("out_data", 32'(out_data), 32'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    // async reset asserted between edges
    #7 rst_n = 1'b0;
    #1 check_state("rst", 2'd0, 1'b0, 1'b1);
    check("rst_data", 32'(out_data), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check_state("idle", 2'd0, 1'b0, 1'b1);
      step();
    end

    // streaming at full throughput
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h8000; step();
    check("str0", 32'(out_data), 32'h8000); check_state("str0", 2'd1, 1'b1, 1'b1);
    in_data = 16'h0001; step();
    check("str1", 32'(out_data), 32'h0001); check_state("str1", 2'd1, 1'b1, 1'b1);
    in_data = 16'h1234; step();
    check("str2", 32'(out_data), 32'h1234); check_state("str2", 2'd1, 1'b1, 1'b1);
    in_valid = 1'b0; step();
    check_state("str_end", 2'd0, 1'b0, 1'b1);

    // backpressure into skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h8000; step();
    check_state("bp0", 2'd1, 1'b1, 1'b1);
    in_data = 16'h0001; step();
    check_state("bp1", 2'd2, 1'b1, 1'b0);
    check("bp1_data", 32'(out_data), 32'h8000);

    // FULL holds with in_valid asserted
    in_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("full", 2'd2, 1'b1, 1'b0);
      check("full_data", 32'(out_data), 32'h8000);
    end

    in_valid = 1'b0; out_ready = 1'b1; step();
    check_state("drain0", 2'd1, 1'b1, 1'b1);
    check("drain0_data", 32'(out_data), 32'h0001);
    step();
    check_state("drain1", 2'd0, 1'b0, 1'b1);

    // flush from FULL drops held words and the flush-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111; step();
    in_data = 16'h2222; step();
    check_state("pre_flush", 2'd2, 1'b1, 1'b0);
    flush = 1'b1; in_data = 16'hAAAA; step();
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    check_state("flush", 2'd0, 1'b0, 1'b1);
    out_ready = 1'b1; step();
    check_state("post_flush", 2'd0, 1'b0, 1'b1);

    // async reset while BUSY
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0001; step();
    in_valid = 1'b0;
    check("busy_data", 32'(out_data), 32'h0001); check_state("busy", 2'd1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_state("mid_rst", 2'd0, 1'b0, 1'b1);
    check("mid_rst_data", 32'(out_data), 32'h0);
    sb.delete();
    #1 rst_n = 1'b1;
    step();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h8000; step();
    in_valid = 1'b0;
    check("rst_lat", 32'(out_data), 32'h8000); check_state("rst_lat", 2'd1, 1'b1, 1'b1);
    step();
    check_state("rst_lat_end", 2'd0, 1'b0, 1'b1);

    // random traffic; occupancy must track the scoreboard depth
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = N'($urandom);
      step();
      check("rnd_occ", 32'(occupancy), 32'(sb.size()));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("final_sb", 32'(sb.size()), 32'h0);
    check_state("final", 2'd0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
